// File: rtl/npc_unit.sv
// npc_unit: next-PC selection and fetch PC register with a return-address stack.
//
// Parameters:
//   W          address width (W >= 8)
//   RESET_PC   PC value loaded on reset
//   EXC_VEC    exception entry address
//   RAS_DEPTH  return-address-stack entries (power of two, 2..16)
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   stall               hold PC and RAS (exc_req / eret still redirect)
//   is_br, br_cond      conditional branch present / condition true
//   is_j, is_jr         absolute jump / register jump
//   jr_is_ra            register jump source is $31 (RAS pop)
//   is_link             instruction writes a return address (RAS push)
//   br_pc, br_off       branch PC and pre-shifted sign-extended offset
//   j_target, jr_target absolute and register jump targets
//   link_addr           return address to push
//   exc_req, eret, epc  exception redirect, exception return and its target
//   pc                  registered fetch PC
//   npc                 combinational next PC
//   ras_top, ras_valid  top RAS entry (0 when empty) and non-empty flag
//   ras_miss            one-cycle pulse after a wrong or empty RAS prediction
//   pc_misalign         pc[1:0] != 0
module npc_unit #(
    parameter int           W         = 32,
    parameter logic [W-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [W-1:0] EXC_VEC   = 32'h0000_4180,
    parameter int           RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stall,
    input  logic         is_br,
    input  logic         br_cond,
    input  logic         is_j,
    input  logic         is_jr,
    input  logic         jr_is_ra,
    input  logic         is_link,
    input  logic [W-1:0] br_pc,
    input  logic [W-1:0] br_off,
    input  logic [W-1:0] j_target,
    input  logic [W-1:0] jr_target,
    input  logic [W-1:0] link_addr,
    input  logic         exc_req,
    input  logic         eret,
    input  logic [W-1:0] epc,
    output logic [W-1:0] pc,
    output logic [W-1:0] npc,
    output logic [W-1:0] ras_top,
    output logic         ras_valid,
    output logic         ras_miss,
    output logic         pc_misalign
);

    localparam int           PW   = $clog2(RAS_DEPTH);
    localparam logic [PW:0]  FULL = (PW+1)'(RAS_DEPTH);

    logic [W-1:0]  ras_mem [RAS_DEPTH];
    logic [PW-1:0] top_ptr, top_ptr_nx;
    logic [PW:0]   count, count_nx;

    logic          accepted, do_push, do_pop;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic          miss_nx;
    logic          pc_load;

    // Next-PC selection, highest priority first.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        npc = pc + W'(4);
        if (exc_req)
            npc = EXC_VEC;
        else if (eret)
            npc = epc;
        else if (is_jr)
            npc = jr_target;
        else if (is_j)
            npc = j_target;
        else if (is_br && br_cond)
            npc = br_pc + br_off;
    end

    // Redirects from exceptions and eret are never held off by stall.
    assign pc_load     = !stall || exc_req || eret;
    assign pc_misalign = |pc[1:0];

    assign ras_valid = (count != '0);
    assign ras_top   = ras_valid ? ras_mem[top_ptr] : '0;

    assign accepted = !stall && !exc_req;
    assign do_push  = accepted && is_link;
    assign do_pop   = accepted && is_jr && jr_is_ra;

    // An empty-stack pop is always a misprediction.
    assign miss_nx = do_pop && (!ras_valid || (jr_target != ras_top));

    // RAS pointer/count update and write port.
    always_comb begin
        top_ptr_nx = top_ptr;
        count_nx   = count;
        wr_en      = 1'b0;
        wr_addr    = top_ptr + PW'(1);
        if (exc_req) begin
            count_nx = '0;
        end else if (do_push && do_pop && ras_valid) begin
            // jalr $31,$31: the return just consumed is replaced in place.
            wr_en   = 1'b1;
            wr_addr = top_ptr;
        end else if (do_push) begin
            // Pointer wraps, so a push on a full stack drops the oldest entry.
            wr_en      = 1'b1;
            top_ptr_nx = top_ptr + PW'(1);
            count_nx   = (count == FULL) ? count : count + (PW+1)'(1);
        end else if (do_pop && ras_valid) begin
            top_ptr_nx = top_ptr - PW'(1);
            count_nx   = count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            top_ptr  <= '0;
            count    <= '0;
            ras_miss <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (pc_load)
                pc <= npc;
            top_ptr  <= top_ptr_nx;
            count    <= count_nx;
            ras_miss <= miss_nx;
        end
    end

    // NOTE: stack storage is deliberately not reset; count == 0 already marks every entry invalid.
    always_ff @(posedge clk) begin
        if (wr_en)
            ras_mem[wr_addr] <= link_addr;
    end

endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: self-checking bench for npc_unit. A queue-based reference model
// (newest return address at the back) is compared against the DUT on every
// falling clock edge; directed sequences add literal expectations.
module tb_npc_unit;

    localparam int          W     = 32;
    localparam logic [31:0] RPC   = 32'h0000_3000;
    localparam logic [31:0] EVEC  = 32'h0000_4180;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, is_br, br_cond, is_j, is_jr, jr_is_ra, is_link;
    logic [31:0] br_pc, br_off, j_target, jr_target, link_addr, epc;
    logic        exc_req, eret;
    logic [31:0] pc, npc, ras_top;
    logic        ras_valid, ras_miss, pc_misalign;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_miss;

    npc_unit #(
        .W(W), .RESET_PC(RPC), .EXC_VEC(EVEC), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .is_br(is_br),
        .br_cond(br_cond), .is_j(is_j), .is_jr(is_jr), .jr_is_ra(jr_is_ra),
        .is_link(is_link), .br_pc(br_pc), .br_off(br_off), .j_target(j_target),
        .jr_target(jr_target), .link_addr(link_addr), .exc_req(exc_req),
        .eret(eret), .epc(epc), .pc(pc), .npc(npc), .ras_top(ras_top),
        .ras_valid(ras_valid), .ras_miss(ras_miss), .pc_misalign(pc_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_npc();
        if (exc_req)             return EVEC;
        if (eret)                return epc;
        if (is_jr)               return jr_target;
        if (is_j)                return j_target;
        if (is_br && br_cond)    return br_pc + br_off;
        return m_pc + 32'd4;
    endfunction

    function automatic logic [31:0] model_top();
        if (m_q.size() == 0) return 32'h0;
        return m_q[$];
    endfunction

    // Compare, then advance the model by the edge that follows. Inputs only
    // change just after a rising edge, so they are the ones that edge samples.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_pc = RPC;
                m_q.delete();
                m_miss = 1'b0;
            end
            check("pc", pc, m_pc);
            check("npc", npc, model_npc());
            check("ras_valid", {31'b0, ras_valid}, {31'b0, m_q.size() != 0});
            check("ras_top", ras_top, model_top());
            check("ras_miss", {31'b0, ras_miss}, {31'b0, m_miss});
            check("pc_misalign", {31'b0, pc_misalign}, {31'b0, m_pc[1:0] != 2'b00});
            if (reset_n) begin
                logic acc, pop, push;
                logic [31:0] nxt;
                nxt  = model_npc();
                acc  = !stall && !exc_req;
                pop  = acc && is_jr && jr_is_ra;
                push = acc && is_link;
                m_miss = pop && (m_q.size() == 0 || jr_target != m_q[$]);
                if (exc_req) begin
                    m_q.delete();
                end else if (push && pop) begin
                    if (m_q.size() == 0) m_q.push_back(link_addr);
                    else                 m_q[m_q.size()-1] = link_addr;
                end else if (push) begin
                    if (m_q.size() == DEPTH) void'(m_q.pop_front());
                    m_q.push_back(link_addr);
                end else if (pop) begin
                    if (m_q.size() != 0) void'(m_q.pop_back());
                end
                if (!stall || exc_req || eret) m_pc = nxt;
            end
        end
    end

    task automatic idle();
        stall = 0; is_br = 0; br_cond = 0; is_j = 0; is_jr = 0; jr_is_ra = 0;
        is_link = 0; exc_req = 0; eret = 0;
        br_pc = 0; br_off = 0; j_target = 0; jr_target = 0; link_addr = 0; epc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        step();
        step();
        reset_n = 1'b1;

        // Reset value, then three sequential fetches.
        check("reset_pc", pc, 32'h3000);
        check("reset_ras_valid", {31'b0, ras_valid}, 32'h0);
        step(); check("seq_pc1", pc, 32'h3004);
        step(); check("seq_pc2", pc, 32'h3008);
        step(); check("seq_pc3", pc, 32'h300C);

        // Taken branch backwards, then not taken (with a push on the side).
        is_br = 1; br_cond = 1; br_pc = 32'h3010; br_off = 32'hFFFF_FFF0;
        step(); check("br_taken", pc, 32'h3000);
        br_cond = 0; is_link = 1; link_addr = 32'h77;
        step(); check("br_not_taken", pc, 32'h3004);
        check("push_valid", {31'b0, ras_valid}, 32'h1);
        idle();
        step(); check("pc_3008", pc, 32'h3008);

        // Stall holds, exception overrides stall and empties the RAS.
        stall = 1;
        step(); check("stall1", pc, 32'h3008);
        step(); check("stall2", pc, 32'h3008);
        exc_req = 1;
        step(); check("exc_in_stall", pc, EVEC);
        check("exc_ras_clear", {31'b0, ras_valid}, 32'h0);
        idle();

        // Five pushes into a four-deep stack, then five pops.
        is_j = 1; is_link = 1; j_target = 32'h200;
        for (int k = 1; k <= 5; k++) begin
            link_addr = 32'h10 * k;
            step();
        end
        idle();
        is_jr = 1; jr_is_ra = 1;
        for (int k = 5; k >= 2; k--) begin
            check("pop_top", ras_top, 32'h10 * k);
            jr_target = 32'h10 * k;
            step();
            check("pop_pc", pc, 32'h10 * k);
            check("pop_hit", {31'b0, ras_miss}, 32'h0);
        end
        check("empty_valid", {31'b0, ras_valid}, 32'h0);
        jr_target = 32'h600;
        step(); check("empty_pop_miss", {31'b0, ras_miss}, 32'h1);
        idle();
        step(); check("miss_pulse_end", {31'b0, ras_miss}, 32'h0);

        // Mismatched return target, then a matching one.
        is_link = 1; link_addr = 32'h100;
        step(); idle();
        is_jr = 1; jr_is_ra = 1; jr_target = 32'h104;
        step(); check("mis_pc", pc, 32'h104);
        check("mis_miss", {31'b0, ras_miss}, 32'h1);
        idle(); is_link = 1; link_addr = 32'h100;
        step(); check("mis_one_cycle", {31'b0, ras_miss}, 32'h0);
        idle(); is_jr = 1; jr_is_ra = 1; jr_target = 32'h100;
        step(); check("hit_miss", {31'b0, ras_miss}, 32'h0);

        // Everything at once: exception wins, then eret.
        idle();
        exc_req = 1; eret = 1; is_jr = 1; is_j = 1; is_br = 1; br_cond = 1;
        epc = 32'h5000; jr_target = 32'h6000; j_target = 32'h7000;
        br_pc = 32'h100; br_off = 32'h8;
        step(); check("prio_exc", pc, EVEC);
        exc_req = 0;
        step(); check("prio_eret", pc, 32'h5000);
        idle();

        // Randomized traffic with one asynchronous mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            stall     = ($urandom % 5) == 0;
            exc_req   = ($urandom % 40) == 0;
            eret      = ($urandom % 30) == 0;
            is_jr     = ($urandom % 5) == 0;
            jr_is_ra  = ($urandom % 4) != 0;
            is_j      = ($urandom % 8) == 0;
            is_br     = ($urandom % 4) == 0;
            br_cond   = $urandom % 2;
            is_link   = ($urandom % 3) == 0;
            br_pc     = $urandom;
            br_off    = ($urandom % 2) ? 32'(($urandom % 64) * 4) : 32'hFFFF_FF00;
            j_target  = ($urandom % 8 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            link_addr = $urandom & 32'h0000_FFFC;
            epc       = $urandom;
            jr_target = (($urandom % 2) != 0 && m_q.size() != 0) ? m_q[$] : $urandom;
            step();
            if (i == 700) begin
                #2 reset_n = 1'b0;
                #1 check("async_reset_pc", pc, RPC);
                check("async_reset_ras", {31'b0, ras_valid}, 32'h0);
                check("async_reset_miss", {31'b0, ras_miss}, 32'h0);
                step();
                reset_n = 1'b1;
            end
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
